// File: rtl/odd_even_sorter.sv
// Odd-even transposition sorter.
// Sorts N lanes of W bits over N compare-exchange phases, one phase per clock.
// A valid/ready handshake on each side; the result is held in DONE until the
// consumer takes it.

// Compare for one adjacent pair: swap is asserted when lo/hi are out of order.
module oe_cmp #(
   parameter int W       = 8,
   parameter bit SIGNED  = 1'b1,
   parameter bit DESCEND = 1'b0
) (
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   output logic         swap
);

   logic gt;
   logic lt;

   generate
      if (SIGNED) begin : g_signed
         assign gt = $signed(lo) > $signed(hi);
         assign lt = $signed(lo) < $signed(hi);
      end else begin : g_unsigned
         assign gt = lo > hi;
         assign lt = lo < hi;
      end
   endgenerate

   // Equal values never swap, because both gt and lt are then low.
   assign swap = DESCEND ? lt : gt;

endmodule

// One lane's next value.
// The lane takes its upper neighbour, its lower neighbour, or keeps itself.
// The two take flags are never both set, because active pairs of a phase never
// overlap.
module oe_lane #(
   parameter int W = 8
) (
   input  logic [W-1:0] self_val,
   input  logic [W-1:0] up_val,
   input  logic [W-1:0] dn_val,
   input  logic         take_up,
   input  logic         take_dn,
   output logic [W-1:0] nxt_val
);

   // Select the new lane value for this phase.
   always_comb begin
      nxt_val = self_val;
      if (take_up)      nxt_val = up_val;
      else if (take_dn) nxt_val = dn_val;
   end

endmodule

module odd_even_sorter #(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter bit SIGNED  = 1'b1,
   parameter bit DESCEND = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] out_data,
   output logic           busy
);

   // One extra bit so the counter can reach N without wrapping.
   localparam int PW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t              state;
   logic [PW-1:0]       phase;
   logic [N-1:0][W-1:0] arr;
   logic [N-1:0][W-1:0] nxt;
   logic [N-2:0]        swap;   // pair (k,k+1) is out of order
   logic [N-2:0]        act;    // pair (k,k+1) takes part in this phase
   logic [N-1:0]        take_up;
   logic [N-1:0]        take_dn;
   logic [N-1:0][W-1:0] up_val;
   logic [N-1:0][W-1:0] dn_val;

   // Pair comparators.
   // Even phases pair from lane 0; odd phases pair from lane 1.
   genvar k;
   generate
      for (k = 0; k < N-1; k++) begin : g_pair
         oe_cmp #(.W(W), .SIGNED(SIGNED), .DESCEND(DESCEND)) u_cmp (
            .lo   (arr[k]),
            .hi   (arr[k+1]),
            .swap (swap[k])
         );
         assign act[k] = (phase[0] == 1'(k % 2));
      end
   endgenerate

   // Neighbour wiring.
   // The end lanes have no partner on one side and are tied to hold.
   // An unpaired lane (N odd) simply sees both take flags low.
   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_lane
         if (i < N-1) begin : g_up
            assign take_up[i] = act[i] & swap[i];
            assign up_val[i]  = arr[i+1];
         end else begin : g_up_tie
            assign take_up[i] = 1'b0;
            assign up_val[i]  = arr[i];
         end
         if (i > 0) begin : g_dn
            assign take_dn[i] = act[i-1] & swap[i-1];
            assign dn_val[i]  = arr[i-1];
         end else begin : g_dn_tie
            assign take_dn[i] = 1'b0;
            assign dn_val[i]  = arr[i];
         end
         oe_lane #(.W(W)) u_lane (
            .self_val (arr[i]),
            .up_val   (up_val[i]),
            .dn_val   (dn_val[i]),
            .take_up  (take_up[i]),
            .take_dn  (take_dn[i]),
            .nxt_val  (nxt[i])
         );
      end
   endgenerate

   // out_data is driven straight from the working array.
   // It is therefore stable for as long as the FSM stays in DONE.
   assign out_data = arr;

   // Control FSM.
   // Handshake and status outputs are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         arr       <= '0;
         phase     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  arr      <= in_data;
                  phase    <= '0;
                  state    <= SORT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SORT: begin
               arr   <= nxt;
               phase <= phase + 1'b1;
               if (phase == PW'(N-1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               // in_ready stays low here, so a reload can only happen after
               // the FSM is back in IDLE.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_odd_even_sorter.sv
// Bench for odd_even_sorter.
// Four configurations run side by side: signed ascending, unsigned ascending,
// unsigned descending, and N=5/W=16.
module tb_odd_even_sorter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv[4];
   logic        ir[4];
   logic        ov[4];
   logic        ordy[4];
   logic        bz[4];
   logic [31:0] id4[3];
   logic [31:0] od4[3];
   logic [79:0] id5;
   logic [79:0] od5;

   int asserts = 0;
   int fails   = 0;

   // Per-instance configuration, used by the reference model.
   int pn[4] = '{4, 4, 4, 5};
   int pw[4] = '{8, 8, 8, 16};
   int ps[4] = '{1, 0, 0, 0};
   int pd[4] = '{0, 0, 1, 0};

   odd_even_sorter #(.N(4), .W(8), .SIGNED(1'b1), .DESCEND(1'b0)) d0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id4[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od4[0]), .busy(bz[0]));
   odd_even_sorter #(.N(4), .W(8), .SIGNED(1'b0), .DESCEND(1'b0)) d1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id4[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od4[1]), .busy(bz[1]));
   odd_even_sorter #(.N(4), .W(8), .SIGNED(1'b0), .DESCEND(1'b1)) d2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id4[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od4[2]), .busy(bz[2]));
   odd_even_sorter #(.N(5), .W(16), .SIGNED(1'b0), .DESCEND(1'b0)) d3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id5),
      .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od5), .busy(bz[3]));

   // Reference model: decode lanes to integer keys and selection-sort them.
   function automatic logic [79:0] ref_sort(input logic [79:0] v, input int sel);
      int          n = pn[sel];
      int          w = pw[sel];
      longint      key[5];
      logic [15:0] val[5];
      logic [15:0] mask;
      logic [79:0] r;
      int          b;
      longint      tk;
      logic [15:0] tv;
      mask = 16'((32'd1 << w) - 1);
      for (int j = 0; j < n; j++) begin
         val[j] = 16'(v >> (j*w)) & mask;
         key[j] = longint'(val[j]);
         if (ps[sel] != 0 && val[j][w-1]) key[j] = key[j] - (longint'(1) << w);
      end
      for (int j = 0; j < n-1; j++) begin
         b = j;
         for (int m = j+1; m < n; m++)
            if (pd[sel] != 0 ? key[m] > key[b] : key[m] < key[b]) b = m;
         tk = key[j]; key[j] = key[b]; key[b] = tk;
         tv = val[j]; val[j] = val[b]; val[b] = tv;
      end
      r = '0;
      for (int j = 0; j < n; j++) r = r | (80'(val[j]) << (j*w));
      return r;
   endfunction

   function automatic logic [79:0] out_of(input int sel);
      return (sel == 3) ? od5 : {48'b0, od4[sel]};
   endfunction

   function automatic logic [79:0] rand_vec(input int sel);
      logic [79:0] v = '0;
      bit          dup = $urandom_range(0, 1) == 1;
      for (int j = 0; j < pn[sel]; j++) begin
         logic [15:0] x;
         x = dup ? 16'($urandom_range(0, 3)) : 16'($urandom);
         if (dup && $urandom_range(0, 1) == 1) x = ~x;
         if (pw[sel] == 8) x = {8'h00, x[7:0]};
         v = v | (80'(x) << (j*pw[sel]));
      end
      return v;
   endfunction

   // Drive one vector through an idle instance.
   // lat counts edges from acceptance (inclusive) to out_valid; -1 on timeout.
   task automatic do_sort(input int sel, input logic [79:0] data, input bit rel,
                          output int lat, output logic [79:0] res);
      @(negedge clk);
      if (sel == 3) id5 = data; else id4[sel] = data[31:0];
      iv[sel] = 1'b1;
      @(posedge clk);
      #1 iv[sel] = 1'b0;
      lat = 1;
      while (lat < 64) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (ov[sel]) break;
      end
      if (!ov[sel]) lat = -1;
      res = out_of(sel);
      if (rel) begin
         ordy[sel] = 1'b1;
         @(posedge clk);
         #1 ordy[sel] = 1'b0;
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 4; s++) begin
         asserts++; if (ir[s] !== 1'b1) begin fails++; $display("FAIL reset_in_ready[%0d] got %b want 1", s, ir[s]); end
         asserts++; if (ov[s] !== 1'b0) begin fails++; $display("FAIL reset_out_valid[%0d] got %b want 0", s, ov[s]); end
         asserts++; if (bz[s] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d] got %b want 0", s, bz[s]); end
         asserts++; if (out_of(s) !== 80'h0) begin fails++; $display("FAIL reset_out_data[%0d] got %h want 0", s, out_of(s)); end
      end
   endtask

   task automatic test_directed();
      int          lat;
      logic [79:0] res;
      logic [79:0] v5;
      logic [79:0] e5;
      do_sort(0, {48'b0, 32'h7FD88080}, 1'b1, lat, res);
      asserts++; if (lat !== 5) begin fails++; $display("FAIL dir_signed_latency got %0d want 5", lat); end
      asserts++; if (res !== {48'b0, 32'h7FD88080}) begin fails++; $display("FAIL dir_signed_data got %h want 7fd88080", res); end
      do_sort(1, {48'b0, 32'h7FD88080}, 1'b1, lat, res);
      asserts++; if (lat !== 5) begin fails++; $display("FAIL dir_unsigned_latency got %0d want 5", lat); end
      asserts++; if (res !== {48'b0, 32'hD880807F}) begin fails++; $display("FAIL dir_unsigned_data got %h want d880807f", res); end
      do_sort(2, {48'b0, 32'h04030201}, 1'b1, lat, res);
      asserts++; if (res !== {48'b0, 32'h01020304}) begin fails++; $display("FAIL dir_descend_data got %h want 01020304", res); end
      v5 = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
      e5 = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
      do_sort(3, v5, 1'b1, lat, res);
      asserts++; if (lat !== 6) begin fails++; $display("FAIL dir_n5_latency got %0d want 6", lat); end
      asserts++; if (res !== e5) begin fails++; $display("FAIL dir_n5_data got %h want %h", res, e5); end
   endtask

   task automatic test_random();
      int          lat;
      logic [79:0] v;
      logic [79:0] res;
      logic [79:0] exp;
      for (int s = 0; s < 4; s++) begin
         for (int t = 0; t < 25; t++) begin
            v   = rand_vec(s);
            exp = ref_sort(v, s);
            do_sort(s, v, 1'b1, lat, res);
            asserts++; if (lat !== pn[s] + 1) begin fails++; $display("FAIL rand_latency[%0d] got %0d want %0d", s, lat, pn[s] + 1); end
            asserts++; if (res !== exp) begin fails++; $display("FAIL rand_data[%0d] in %h got %h want %h", s, v, res, exp); end
         end
      end
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [79:0] v;
      logic [79:0] res;
      logic [79:0] exp;
      v   = rand_vec(0);
      exp = ref_sort(v, 0);
      do_sort(0, v, 1'b0, lat, res);
      asserts++; if (res !== exp) begin fails++; $display("FAIL bp_first_data got %h want %h", res, exp); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         asserts++; if (od4[0] !== exp[31:0]) begin fails++; $display("FAIL bp_hold_data cyc %0d got %h want %h", c, od4[0], exp[31:0]); end
         asserts++; if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin fails++; $display("FAIL bp_hold_flags cyc %0d got ir=%b ov=%b want ir=0 ov=1", c, ir[0], ov[0]); end
         if (c == 3) begin id4[0] = 32'h01020304; iv[0] = 1'b1; end
         if (c == 5) iv[0] = 1'b0;
      end
      ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      asserts++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin fails++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", ir[0], ov[0]); end
      ordy[0] = 1'b0;
      v   = rand_vec(0);
      exp = ref_sort(v, 0);
      do_sort(0, v, 1'b1, lat, res);
      asserts++; if (res !== exp) begin fails++; $display("FAIL bp_next_data got %h want %h", res, exp); end
   endtask

   task automatic test_reset_mid();
      int          lat;
      logic [79:0] res;
      @(negedge clk);
      id4[0] = 32'h11223344;
      iv[0]  = 1'b1;
      @(posedge clk);
      #1 iv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      asserts++; if (bz[0] !== 1'b1) begin fails++; $display("FAIL rm_busy_before got %b want 1", bz[0]); end
      rst = 1'b1;
      #1;
      asserts++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin fails++; $display("FAIL rm_flags got ov=%b bz=%b ir=%b want 0 0 1", ov[0], bz[0], ir[0]); end
      asserts++; if (od4[0] !== 32'h0) begin fails++; $display("FAIL rm_data got %h want 0", od4[0]); end
      @(negedge clk);
      rst = 1'b0;
      do_sort(0, {48'b0, 32'h20300010}, 1'b1, lat, res);
      asserts++; if (res !== {48'b0, 32'h30201000}) begin fails++; $display("FAIL rm_after_data got %h want 30201000", res); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      id5 = '0;
      for (int s = 0; s < 4; s++) begin iv[s] = 1'b0; ordy[s] = 1'b0; end
      for (int s = 0; s < 3; s++) id4[s] = '0;
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
